// File: rtl/jesd204_rx_char_replace_if.sv
// Beat bus between the JESD204 RX lane datapath and the character replacement stage.
interface jesd204_rx_char_replace_if;

  logic        in_valid;
  logic [31:0] in_data;
  logic [3:0]  in_charisk;

  logic        out_valid;
  logic [31:0] out_data;
  logic [3:0]  out_charisk;
  logic        char_err;
  logic [7:0]  err_count;

  // Upstream side: supplies beats, observes the result
  modport master (
    output in_valid, in_data, in_charisk,
    input  out_valid, out_data, out_charisk, char_err, err_count
  );

  // Replacement block side
  modport slave (
    input  in_valid, in_data, in_charisk,
    output out_valid, out_data, out_charisk, char_err, err_count
  );

endinterface

// File: rtl/jesd204_rx_char_replace.sv
// JESD204 RX alignment character replacement: turns /F/ and /A/ control octets at
// frame / multiframe ends back into data and flags misplaced control characters.
module jesd204_rx_char_replace #(
  parameter int unsigned OCTETS_PER_FRAME = 4
) (
  input  logic                          clk,
  input  logic                          resetn,
  input  logic                          enable,
  input  logic                          cfg_scrambled,
  input  logic [7:0]                    cfg_beats_per_mf,
  input  logic                          mf_start,
  jesd204_rx_char_replace_if.slave      lane
);

  localparam int unsigned NUM_OCTETS = 4;
  localparam int unsigned OCTET_W    = 8;
  localparam int unsigned BEAT_W     = NUM_OCTETS * OCTET_W;
  localparam int unsigned BCNT_W     = 8;
  localparam int unsigned ERRCNT_W   = 8;
  localparam logic [OCTET_W-1:0] CHAR_F = 8'hFC;
  localparam logic [OCTET_W-1:0] CHAR_A = 8'h7C;
  localparam logic [ERRCNT_W-1:0] ERRCNT_MAX = '1;

  // Registered state
  logic [BCNT_W-1:0]     bcnt_q,        bcnt_d;
  logic [OCTET_W-1:0]    prev_oct_q;
  logic                  out_valid_q;
  logic [BEAT_W-1:0]     out_data_q;
  logic [NUM_OCTETS-1:0] out_charisk_q;
  logic                  char_err_q,    char_err_d;
  logic [ERRCNT_W-1:0]   err_count_q,   err_count_d;

  // Combinational beat results
  logic [BCNT_W-1:0]     beat_idx;
  logic                  mf_last_beat;
  logic [BEAT_W-1:0]     data_d;
  logic [NUM_OCTETS-1:0] charisk_d;
  logic [NUM_OCTETS-1:0] misplaced;
  logic [OCTET_W-1:0]    oct;
  logic [OCTET_W-1:0]    prev;
  int unsigned           prev_idx;
  logic                  frame_end;
  logic                  mf_end;

  // Beat position within the multiframe; mf_start restarts the count at the current/next valid beat
  always_comb begin
    beat_idx     = mf_start ? '0 : bcnt_q;
    mf_last_beat = (beat_idx == cfg_beats_per_mf);
    bcnt_d       = bcnt_q;
    if (lane.in_valid) begin
      bcnt_d = mf_last_beat ? '0 : beat_idx + BCNT_W'(1);
    end else if (mf_start) begin
      bcnt_d = '0;
    end
  end

  // Per-octet replacement, earliest octet first so chained replacements see replaced values
  always_comb begin
    data_d    = lane.in_data;
    charisk_d = lane.in_charisk;
    misplaced = '0;
    oct       = '0;
    prev      = '0;
    prev_idx  = 0;
    frame_end = 1'b0;
    mf_end    = 1'b0;
    for (int i = 0; i < NUM_OCTETS; i++) begin
      oct       = lane.in_data[OCTET_W*i +: OCTET_W];
      // Octet i-F of this beat when it exists, else octet 3 of the previous valid beat
      prev_idx  = (i + NUM_OCTETS - OCTETS_PER_FRAME) % NUM_OCTETS;
      prev      = (i >= int'(OCTETS_PER_FRAME)) ? data_d[OCTET_W*prev_idx +: OCTET_W] : prev_oct_q;
      frame_end = (((i + 1) % OCTETS_PER_FRAME) == 0);
      mf_end    = (i == NUM_OCTETS - 1) && mf_last_beat;
      if (enable && lane.in_charisk[i]) begin
        if (frame_end && ((oct == CHAR_F) || ((oct == CHAR_A) && mf_end))) begin
          charisk_d[i] = 1'b0;
          if (!cfg_scrambled) begin
            data_d[OCTET_W*i +: OCTET_W] = prev;
          end
        end else begin
          misplaced[i] = 1'b1;
        end
      end
    end
  end

  // Error pulse and saturating error counter
  always_comb begin
    char_err_d  = lane.in_valid && (|misplaced);
    err_count_d = err_count_q;
    if (char_err_d && (err_count_q != ERRCNT_MAX)) begin
      err_count_d = err_count_q + ERRCNT_W'(1);
    end
  end

  // Output and state registers; data path and previous octet only move on valid beats
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      bcnt_q        <= '0;
      prev_oct_q    <= '0;
      out_valid_q   <= 1'b0;
      out_data_q    <= '0;
      out_charisk_q <= '0;
      char_err_q    <= 1'b0;
      err_count_q   <= '0;
    end else begin
      bcnt_q      <= bcnt_d;
      out_valid_q <= lane.in_valid;
      char_err_q  <= char_err_d;
      err_count_q <= err_count_d;
      if (lane.in_valid) begin
        out_data_q    <= data_d;
        out_charisk_q <= charisk_d;
        prev_oct_q    <= data_d[BEAT_W-1 -: OCTET_W];
      end
    end
  end

  assign lane.out_valid   = out_valid_q;
  assign lane.out_data    = out_data_q;
  assign lane.out_charisk = out_charisk_q;
  assign lane.char_err    = char_err_q;
  assign lane.err_count   = err_count_q;

endmodule

// File: doc/jesd204_rx_char_replace.md
JESD204_RX_CHAR_REPLACE -- requirements
Module: jesd204_rx_char_replace

Interface
REQ-001 SHALL have parameter OCTETS_PER_FRAME, default 4, octets per frame F, legal values 1, 2, 4.
REQ-002 SHALL have port clk  input  1  sole clock; all logic rising-edge.
REQ-003 SHALL have port resetn  input  1  asynchronous active-low reset.
REQ-004 SHALL have port enable  input  1  1 = replacement and checking active, 0 = pass-through.
REQ-005 SHALL have port cfg_scrambled  input  1  1 = link scrambling on, i.e. descrambled data feeds this block.
REQ-006 SHALL have port cfg_beats_per_mf  input  8  beats per multiframe minus 1.
REQ-007 SHALL have port mf_start  input  1  pulse marking the first beat of a multiframe.
REQ-008 SHALL have port in_valid  input  1  beat qualifier.
REQ-009 SHALL have port in_data  input  32  four octets, octet 0 = bits 7:0, earliest octet.
REQ-010 SHALL have port in_charisk  input  4  per-octet control flag.
REQ-011 SHALL have port out_valid, out_data, out_charisk  output  1/32/4  registered result.
REQ-012 SHALL have port char_err  output  1  one-cycle pulse per beat with at least one misplaced character.
REQ-013 SHALL have port err_count  output  8  saturating count of char_err pulses.

Function
REQ-014 SHALL keep beat counter bcnt (8 bit), advancing only on in_valid, wrapping to 0 after value cfg_beats_per_mf.
REQ-015 SHALL set bcnt so the current beat is beat 0 when mf_start and in_valid coincide; mf_start without in_valid makes the next valid beat beat 0.
REQ-016 SHALL treat octet i as frame end when (i+1) mod F = 0, and octet 3 of beat bcnt = cfg_beats_per_mf as multiframe end.
REQ-017 SHALL call /F/ a control octet 0xFC and /A/ a control octet 0x7C.
REQ-018 SHALL, with enable=1 and cfg_scrambled=0, replace /F/ at a frame end and /A/ at a multiframe end with the last octet of the previous frame, and clear that octet's charisk.
REQ-019 SHALL take the previous-frame octet from the post-replacement output stream: octet i-F within the beat, else the stored octet 3 of the previous valid beat.
REQ-020 SHALL, with enable=1 and cfg_scrambled=1, keep the data value of replaced /F/ or /A/ and clear its charisk.
REQ-021 SHALL flag as misplaced, and pass through unchanged with charisk kept: a control octet not at a frame end; /A/ at a frame end that is not a multiframe end; any control octet other than 0xFC or 0x7C.
REQ-022 SHALL accept /F/ at a multiframe end as a legal replacement.
REQ-023 SHALL, with enable=0, pass data and charisk unchanged and assert no char_err, while bcnt keeps advancing.
REQ-024 SHALL register all outputs with exactly one cycle latency: out_valid(t+1)=in_valid(t), and hold out_data/out_charisk when in_valid=0.
REQ-025 SHALL pulse char_err only on a cycle where out_valid=1.
REQ-026 SHALL increment err_count with each char_err pulse and saturate at 255.
REQ-027 SHALL update the stored previous octet only on in_valid beats.

Reset
REQ-028 SHALL, while resetn=0, force out_valid, out_data, out_charisk, char_err, err_count, bcnt and the stored previous octet to 0, asynchronously.
REQ-029 SHALL start from bcnt=0 on the first valid beat after reset release, and substitute stored octet 0x00 if that beat needs a previous-frame value.

Verification
REQ-030 SHALL cover F=4, scrambling off, cfg_beats_per_mf=3: beat0 data 0x44332211, beat1 data 0xFC222222 with charisk 4'b1000 -> beat1 out data 0x44222222, charisk 0, char_err 0.
REQ-031 SHALL cover F=1, scrambling off: one beat data 0xFCFCFC55 with charisk 4'b1110 -> out data 0x55555555 (chained), charisk 0.
REQ-032 SHALL cover F=4, cfg_beats_per_mf=1: /A/ at octet 3 of beat 1 -> replaced. /A/ at octet 3 of beat 0 -> passed unchanged with charisk set, char_err pulse, err_count 1.
REQ-033 SHALL cover F=2, scrambling on: data 0x7CFCFCFC with charisk 4'b1010 on the multiframe-end beat -> out data unchanged, charisk 0, no error. Then charisk 4'b0001 -> char_err.
REQ-034 SHALL cover error saturation and reset: 300 misplaced beats -> err_count 255. Assert resetn low mid-stream -> all outputs 0 immediately, and the next valid beat is beat 0.
